// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serializes instruction fetch and load/store onto one
// wait-state bus, data first. Define MEM_ARB_TIMEOUT_EN to add the busy-timeout abort.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_sel,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  output logic        m_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  logic   in_access;
  logic   timed_out;

  assign in_access = (state == FETCH) || (state == DATA);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] busy_cnt;
  logic [CW-1:0] busy_cnt_next;

  assign busy_cnt_next = busy_cnt + 1'b1;
  assign timed_out     = in_access && m_busy && (busy_cnt_next == CW'(TIMEOUT_CYCLES));

  // Counter sits at zero outside an access, so every grant starts a fresh count.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy_cnt <= '0;
      m_error  <= 1'b0;
    end else begin
      if (!in_access)  busy_cnt <= '0;
      else if (m_busy) busy_cnt <= busy_cnt_next;
      if (timed_out)   m_error  <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign m_error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the datapath registers are cleared too, so the bus never shows stale
      // addresses or data after a reset that lands mid-access.
      state   <= IDLE;
      m_addr  <= '0;
      m_wdata <= '0;
      m_sel   <= '0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_read || d_write) begin
            state   <= DATA;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_sel   <= d_sel;
            m_read  <= d_read;
            m_write <= d_write;
          end else if (i_req) begin
            state   <= FETCH;
            m_addr  <= i_addr;
            m_sel   <= 4'hF;
            m_read  <= 1'b1;
            m_write <= 1'b0;
          end
        end

        FETCH, DATA: begin
          // A normal completion takes precedence over a timeout on the same edge.
          if (!m_busy || timed_out) begin
            if (m_read) begin
              if (state == FETCH) i_rdata <= m_busy ? '0 : m_rdata;
              else                d_rdata <= m_busy ? '0 : m_rdata;
            end
            m_read  <= 1'b0;
            m_write <= 1'b0;
            i_ready <= (state == FETCH);
            d_ready <= (state == DATA);
            state   <= RESP;
          end
        end

        RESP: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; exercises the timeout path
// only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nRST;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_sel;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_rdata;
  logic        m_busy;
  logic        m_error;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
`ifdef MEM_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES(4)
`else
    .TIMEOUT_CYCLES(255)
`endif
  ) dut (
    .clk    (clk),
    .nRST   (nRST),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_ready(i_ready),
    .d_read (d_read),
    .d_write(d_write),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_sel  (d_sel),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_sel  (m_sel),
    .m_read (m_read),
    .m_write(m_write),
    .m_rdata(m_rdata),
    .m_busy (m_busy),
    .m_error(m_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nRST    = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_sel   = '0;
    m_rdata = '0;
    m_busy  = 1'b0;
    tick();
    tick();
    check("rst_m_read",  m_read,  0);
    check("rst_m_write", m_write, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_m_error", m_error, 0);
    check("rst_m_addr",  m_addr,  0);
    check("rst_m_sel",   m_sel,   0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    nRST = 1'b1;
    tick();

    // Zero-wait fetch
    i_req   = 1'b1;
    i_addr  = 32'h0000_0040;
    m_rdata = 32'h0010_0093;
    tick();
    check("zf_m_read",  m_read,  1);
    check("zf_m_sel",   m_sel,   4'hF);
    check("zf_m_addr",  m_addr,  32'h0000_0040);
    check("zf_early",   i_ready, 0);
    tick();
    check("zf_i_ready", i_ready, 1);
    check("zf_i_rdata", i_rdata, 32'h0010_0093);
    check("zf_drop",    m_read,  0);
    i_req = 1'b0;
    tick();
    check("zf_pulse",   i_ready, 0);

    // Load with three wait states
    d_read  = 1'b1;
    d_addr  = 32'h0000_0100;
    m_busy  = 1'b1;
    m_rdata = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("ws_m_read",  m_read,  1);
      check("ws_m_addr",  m_addr,  32'h0000_0100);
      check("ws_d_ready", d_ready, 0);
      tick();
    end
    check("ws_hold",    m_read,  1);
    check("ws_addr",    m_addr,  32'h0000_0100);
    m_busy  = 1'b0;
    m_rdata = 32'hCAFE_F00D;
    tick();
    check("ws_ready",   d_ready, 1);
    check("ws_d_rdata", d_rdata, 32'hCAFE_F00D);
    check("ws_i_hold",  i_rdata, 32'h0010_0093);
    d_read = 1'b0;
    tick();
    check("ws_pulse",   d_ready, 0);

    // Simultaneous store and fetch: store wins, fetch follows
    d_write = 1'b1;
    d_addr  = 32'h0000_0200;
    d_wdata = 32'h1234_5678;
    d_sel   = 4'b0011;
    i_req   = 1'b1;
    i_addr  = 32'h0000_0044;
    m_rdata = 32'h1111_1111;
    tick();
    check("sim_m_write", m_write, 1);
    check("sim_m_read",  m_read,  0);
    check("sim_m_addr",  m_addr,  32'h0000_0200);
    check("sim_m_wdata", m_wdata, 32'h1234_5678);
    check("sim_m_sel",   m_sel,   4'b0011);
    tick();
    check("sim_d_ready", d_ready, 1);
    check("sim_i_ready", i_ready, 0);
    check("sim_d_keep",  d_rdata, 32'hCAFE_F00D);
    d_write = 1'b0;
    tick();
    check("sim_resp_ig", m_read,  0);
    check("sim_d_pulse", d_ready, 0);
    tick();
    check("sim_f_grant", m_read,  1);
    check("sim_f_addr",  m_addr,  32'h0000_0044);
    check("sim_f_sel",   m_sel,   4'hF);
    tick();
    check("sim_f_ready", i_ready, 1);
    check("sim_f_rdata", i_rdata, 32'h1111_1111);

    // Back-to-back fetch with i_req held
    for (int n = 0; n < 2; n++) begin
      m_rdata = 32'hA000_0000 + 32'(n);
      tick();
      check("b2b_idle_rdy", i_ready, 0);
      check("b2b_idle_rd",  m_read,  0);
      tick();
      check("b2b_fetch",    m_read,  1);
      check("b2b_early",    i_ready, 0);
      tick();
      check("b2b_ready",    i_ready, 1);
      check("b2b_rdata",    i_rdata, 32'hA000_0000 + 32'(n));
    end
    i_req = 1'b0;
    tick();
    tick();
    check("b2b_stop", m_read, 0);

    // Reset mid-store
    d_write = 1'b1;
    d_addr  = 32'h0000_0300;
    d_wdata = 32'h0BAD_0BAD;
    d_sel   = 4'hF;
    m_busy  = 1'b1;
    tick();
    check("mr_m_write", m_write, 1);
    #2 nRST = 1'b0;
    #1;
    check("mr_write0",  m_write, 0);
    check("mr_ready0",  d_ready, 0);
    check("mr_error0",  m_error, 0);
    check("mr_addr0",   m_addr,  0);
    check("mr_rdata0",  d_rdata, 0);
    d_write = 1'b0;
    m_busy  = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    check("mr_no_rdy",  d_ready, 0);
    check("mr_idle_wr", m_write, 0);
    tick();
    check("mr_no_rdy2", d_ready, 0);
    check("mr_idle_rd", m_read,  0);

    // Zero-wait load after reset recovery
    d_read  = 1'b1;
    d_addr  = 32'h0000_0104;
    m_rdata = 32'h0BAD_CAFE;
    tick();
    check("zl_m_read", m_read, 1);
    tick();
    check("zl_ready",  d_ready, 1);
    check("zl_rdata",  d_rdata, 32'h0BAD_CAFE);
    d_read = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Load with m_busy stuck high aborts after four busy cycles
    d_read  = 1'b1;
    d_addr  = 32'h0000_0400;
    m_busy  = 1'b1;
    m_rdata = 32'h5555_5555;
    tick();
    check("to_m_read", m_read,  1);
    check("to_err0",   m_error, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_waiting", m_read,  1);
      check("to_no_rdy",  d_ready, 0);
    end
    tick();
    check("to_drop",   m_read,  0);
    check("to_ready",  d_ready, 1);
    check("to_rdata",  d_rdata, 0);
    check("to_error",  m_error, 1);
    d_read = 1'b0;
    m_busy = 1'b0;
    tick();
    check("to_pulse",  d_ready, 0);
    tick();
    check("to_sticky", m_error, 1);
    #2 nRST = 1'b0;
    #1;
    check("to_rst_err", m_error, 0);
    tick();
    nRST = 1'b1;
    tick();
`else
    check("no_to_err", m_error, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch path (PC) and the load/store path. It sits between the core and the unified memory bus. It serializes fetch and data requests onto one bus with a wait-state handshake, and returns one-cycle `i_ready` / `d_ready` completion pulses. `i_ready` is the signal that lets the PC advance.

## Interface
- `TIMEOUT_CYCLES`, 255 — bus-busy cycles before abort (used only with timeout compiled in)
- `clk` in 1 — clock
- `nRST` in 1 — reset, asynchronous, active-low
- `i_req` in 1 — fetch request, held until `i_ready`
- `i_addr` in 32 — fetch address (PC)
- `i_rdata` out 32 — fetched instruction, valid while `i_ready`=1
- `i_ready` out 1 — fetch complete, one-cycle pulse
- `d_read` in 1 — load request
- `d_write` in 1 — store request (`d_read` and `d_write` are never both high)
- `d_addr` in 32 — data address
- `d_wdata` in 32 — store data
- `d_sel` in 4 — byte enables
- `d_rdata` out 32 — load data, valid while `d_ready`=1
- `d_ready` out 1 — data access complete, one-cycle pulse
- `m_addr` out 32 — bus address
- `m_wdata` out 32 — bus write data
- `m_sel` out 4 — bus byte enables (4'hF for fetch)
- `m_read` out 1 — bus read strobe
- `m_write` out 1 — bus write strobe
- `m_rdata` in 32 — bus read data
- `m_busy` in 1 — memory busy; access completes on the first sampled low
- `m_error` out 1 — sticky timeout flag

## Operation
- FSM states: IDLE, FETCH, DATA, RESP.
- **IDLE:** samples requests at the clock edge.
  - A data request (`d_read|d_write`) has priority and goes to DATA.
  - Otherwise `i_req` goes to FETCH.
  - Otherwise stay in IDLE.
- **Request capture on grant:** address, wdata, sel and direction are registered into the `m_*` outputs. Requester inputs are not re-sampled during the access.
- **FETCH/DATA:**
  - `m_read` or `m_write` is held high.
  - At each edge with `m_busy`=0:
    - reads latch `m_rdata` into `i_rdata`/`d_rdata`;
    - strobes drop;
    - go to RESP.
- **RESP:** exactly one cycle. The matching `i_ready` or `d_ready` is 1. Requests are ignored. Always returns to IDLE.
- Requesters deassert the cycle after their ready pulse. A request still high in the following IDLE cycle is treated as a new request.
- **Read data hold:** `i_rdata`/`d_rdata` hold their value until the next completion of the same type. Stores leave `d_rdata` unchanged.
- **Priority:** data requests are served before fetch when both are pending. Fetch can starve only while data requests are continuously present.
- **Reset (async, any state, including mid-access):**
  - state goes to IDLE;
  - `m_read`, `m_write`, `i_ready`, `d_ready` and `m_error` go to 0;
  - `m_addr`, `m_wdata`, `i_rdata` and `d_rdata` go to 0;
  - `m_sel` goes to 0.

## Timing
- Zero-wait memory (`m_busy`=0 throughout):
  - request seen at edge k;
  - strobe high during cycle k→k+1;
  - completion sampled at edge k+1;
  - ready high during cycle k+1→k+2.
- Latency = 2 + W cycles, where W is the number of sampled `m_busy`=1 cycles.
- Throughput is one access per 3 + W cycles. The RESP and IDLE cycles are mandatory.
- All outputs are registered. No combinational path exists from requester inputs to `m_*` or to the ready outputs.
- `m_addr`/`m_sel`/`m_wdata` stay stable for the whole time the strobe is asserted.

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined:**
  - A counter clears on entry to FETCH/DATA and increments on each sampled `m_busy`=1.
  - When the count reaches `TIMEOUT_CYCLES`:
    - the access is aborted and strobes drop;
    - returned read data is 32'h0;
    - `m_error` is set (sticky until reset);
    - RESP pulses the ready as usual.
  - Completion and timeout on the same edge: completion wins.
- **Undefined:** the arbiter waits indefinitely on `m_busy`. `m_error` is tied 0. No counter is present.

## Test plan
- **Reset:** assert `nRST`=0 mid-DATA with `m_write`=1 → `m_write`, `d_ready` and `m_error` go 0 immediately. State IDLE after release. No ready pulse.
- **Zero-wait fetch:** `i_req`=1, `i_addr`=0x0000_0040, `m_rdata`=0x0010_0093 → `m_read`=1, `m_sel`=4'hF for 1 cycle. `i_ready`=1 with `i_rdata`=0x0010_0093 exactly 2 cycles after the request edge.
- **Wait states:** load at 0x100 with `m_busy`=1 for 3 cycles, then `m_rdata`=0xCAFEF00D → `d_ready` 5 cycles after request. `d_rdata`=0xCAFEF00D. `m_addr` stable throughout.
- **Simultaneous requests:** `d_write` (addr 0x200, wdata 0x12345678, sel 4'b0011) and `i_req` in the same cycle → store completes first (`d_ready`). Fetch is then granted from the next IDLE. `i_ready` arrives 3 cycles after `d_ready` with zero-wait memory.
- **Back-to-back fetch:** `i_req` held continuously → one `i_ready` pulse every 3 cycles with zero-wait memory. A request still high during RESP is not double-granted.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=4):** `m_busy` stuck at 1 on a load → strobe drops after 4 busy cycles. `d_ready`=1 with `d_rdata`=0. `m_error`=1 stays high until reset.
